// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the four digit values from a multiplexed,
// active-low 7-segment display bus by watching which anode is driven and
// capturing the segment pattern once it has been stable for STABLE_CYC samples.
//
// Build option: define SEG_DP_CAPTURE_EN to also capture the decimal point
// (seg[7]) per digit; otherwise dp is tied low and seg[7] is ignored.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   seg[7:0]    segment bus, active-low (seg[0]=a .. seg[6]=g, seg[7]=dp)
//   an[3:0]     anode selects, active-low (an[k]=0 selects digit k)
//   D0..D3      last captured value of each digit (4'hF = blank)
//   valid[3:0]  digit k captured since reset or scan loss
//   frame_done  one-cycle pulse after all four digits have been captured
//   err         one-cycle pulse on illegal segment code or multiple anodes
//   scan_lost   high while the anodes have been idle for TIMEOUT_CYC cycles
//   dp[3:0]     captured decimal point per digit (active-high)
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg,
  input  logic [3:0] an,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       err,
  output logic       scan_lost,
  output logic [3:0] dp
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = 25;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  STAB     = CNT_W'(STABLE_CYC);
  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;
  localparam logic [IDLE_W-1:0] TMO      = IDLE_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              at_stab_q;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [3:0][3:0]   digits_q, digits_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0]        seen_q, seen_d;
  logic              frame_q, frame_d;
  logic              err_q, err_d;
  logic              lost_q, lost_d;

  logic              same_c;
  logic              onehot_c;
  logic [1:0]        dig_c;
  logic [3:0]        dig_oh_c;
  logic              stab_hit_c;
  logic              changed_c;
  logic              capture_c;
  logic              good_c;
  logic              dec_ok_c;
  logic [3:0]        dec_val_c;

`ifdef SEG_DP_CAPTURE_EN
  logic              dps_q;
  logic [3:0]        dp_q, dp_d;
`else
  logic              unused_seg7;
  assign unused_seg7 = seg[7];
`endif

  // Active-low 7-segment code to digit value; ok=0 for codes outside the table.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h7F:   decode = {1'b1, 4'hF};
      default: decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    lost_d   = lost_q;
    onehot_c = 1'b1;
    dig_c    = 2'd0;

    // Stability counter compares the incoming sample with the registered one.
    same_c = (an == an_q) && (seg[6:0] == seg_q);
`ifdef SEG_DP_CAPTURE_EN
    same_c = same_c && (seg[7] == dps_q);
    dp_d   = dp_q;
`endif
    if (same_c) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    else        cnt_d = CNT_W'(1);

    if (an == 4'hF) idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
    else            idle_d = '0;

    case (an_q)
      4'hE:    dig_c = 2'd0;
      4'hD:    dig_c = 2'd1;
      4'hB:    dig_c = 2'd2;
      4'h7:    dig_c = 2'd3;
      default: onehot_c = 1'b0;
    endcase
    dig_oh_c = 4'b0001 << dig_c;

    // at_stab_q makes the window-complete event fire once even at saturation.
    stab_hit_c = (cnt_q == STAB) && !at_stab_q;
    changed_c  = (cnt_q == CNT_W'(1));
    {dec_ok_c, dec_val_c} = decode(seg_q);

    capture_c = (state_q == S_SETTLE) && onehot_c && stab_hit_c;
    good_c    = capture_c && dec_ok_c;
    err_d     = (capture_c && !dec_ok_c) ||
                (stab_hit_c && !onehot_c && (an_q != 4'hF));

    if (!onehot_c) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_SETTLE;
        S_SETTLE: if (stab_hit_c) state_d = S_HELD;
        S_HELD:   if (changed_c) state_d = S_SETTLE;
        default:  state_d = S_IDLE;
      endcase
    end

    // A full mask is reported and cleared; a capture in that cycle lands in the new mask.
    frame_d = (seen_q == 4'hF);
    if (frame_d) seen_d = 4'h0;

    if (good_c) begin
      digits_d[dig_c] = dec_val_c;
      valid_d         = valid_q | dig_oh_c;
      seen_d          = seen_d | dig_oh_c;
      lost_d          = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_d[dig_c]     = ~dps_q;
`endif
    end

    if (idle_d >= TMO) begin
      lost_d  = 1'b1;
      valid_d = 4'h0;
      seen_d  = 4'h0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      cnt_q     <= '0;
      at_stab_q <= 1'b0;
      idle_q    <= '0;
      digits_q  <= '0;
      valid_q   <= 4'h0;
      seen_q    <= 4'h0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dps_q     <= 1'b1;
      dp_q      <= 4'h0;
`endif
    end else begin
      state_q   <= state_d;
      an_q      <= an;
      seg_q     <= seg[6:0];
      cnt_q     <= cnt_d;
      at_stab_q <= (cnt_q == STAB);
      idle_q    <= idle_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
`ifdef SEG_DP_CAPTURE_EN
      dps_q     <= seg[7];
      dp_q      <= dp_d;
`endif
    end
  end

  assign D0         = digits_q[0];
  assign D1         = digits_q[1];
  assign D2         = digits_q[2];
  assign D3         = digits_q[3];
  assign valid      = valid_q;
  assign frame_done = frame_q;
  assign err        = err_q;
  assign scan_lost  = lost_q;
`ifdef SEG_DP_CAPTURE_EN
  assign dp         = dp_q;
`else
  assign dp         = 4'h0;
`endif

endmodule
